// File: rtl/gpio_apb_arbiter_if.sv
// Bundle of requester command/response lines and GPIO APB pins.
// Latency: none, wiring only.
// Backpressure: requesters hold commands until req_ready; the APB side stalls via PREADY.
//
// Signal groups:
//   requester side : req_valid, req_write, req_addr, req_wdata -> req_ready, rsp_valid, rsp_rdata, rsp_err
//   APB side       : PSEL, PENABLE, PWrite, PADDR, PWDATA     <- PRDATA, PREADY
// Modports:
//   master : the arbiter (drives APB and the per-requester handshakes)
//   slave  : the environment (requesters plus GPIO APB slave)
interface gpio_apb_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int AW    = 8,
    parameter int DW    = 16
) ();
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_write;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_wdata;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                rsp_err;

    logic                PSEL;
    logic                PENABLE;
    logic                PWrite;
    logic [AW-1:0]       PADDR;
    logic [DW-1:0]       PWDATA;
    logic [DW-1:0]       PRDATA;
    logic                PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWrite, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWrite, PADDR, PWDATA
    );
endinterface

// File: rtl/gpio_apb_arbiter.sv
// Round-robin APB master sharing one GPIO APB slave among N_REQ requesters.
// Latency: request edge -> SETUP (1) -> ACCESS (>=1) -> rsp_valid; 3 cycles per transfer with PREADY high.
// Backpressure: one command in flight; requesters wait for req_ready, ACCESS stretches while PREADY is low.
//
// Ports:
//   PCLK     : clock, posedge
//   PRESETn  : asynchronous active-low reset
//   bus      : gpio_apb_arbiter_if.master (requester handshakes + APB pins)
// Optional feature macro: APB_TIMEOUT_EN -- abort ACCESS after TIMEOUT_CYC wait cycles
// and report it with rsp_err. Without it ACCESS waits forever and rsp_err is tied low.
module gpio_apb_arbiter #(
    parameter int N_REQ       = 4,
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    gpio_apb_arbiter_if.master  bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Elaboration-time parameter sanity.
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("gpio_apb_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("gpio_apb_arbiter: TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gnt;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [AW-1:0]     paddr_q;
    logic [DW-1:0]     pwdata_q;
    logic [N_REQ-1:0]  req_ready_q;
    logic [N_REQ-1:0]  rsp_valid_q;
    logic [DW-1:0]     rsp_rdata_q;

    // Wrap-around increment used both for the search scan and the pointer update.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(N_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] v);
        return {{(N_REQ-1){1'b0}}, 1'b1} << v;
    endfunction

    // First pending requester at or after the pointer, wrapping modulo N_REQ.
    logic              found;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     scan;

    always_comb begin
        found = 1'b0;
        sel   = ptr;
        scan  = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && bus.req_valid[scan]) begin
                found = 1'b1;
                sel   = scan;
            end
            scan = wrap_inc(scan);
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt;
    logic          rsp_err_q;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= S_IDLE;
            ptr         <= '0;
            gnt         <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt     <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            // Handshake pulses last exactly one cycle.
            req_ready_q <= '0;
            rsp_valid_q <= '0;
`ifdef APB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    if (found) begin
                        pwrite_q    <= bus.req_write[sel];
                        paddr_q     <= bus.req_addr[sel*AW +: AW];
                        pwdata_q    <= bus.req_wdata[sel*DW +: DW];
                        gnt         <= sel;
                        ptr         <= wrap_inc(sel);
                        psel_q      <= 1'b1;
                        req_ready_q <= onehot(sel);
                        state       <= S_SETUP;
                    end else begin
                        // Address/data hold their last values while idle.
                        pwrite_q <= 1'b0;
                    end
                end

                S_SETUP: begin
                    penable_q <= 1'b1;
                    state     <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end

                S_ACCESS: begin
                    // PREADY is checked first so it beats a simultaneous terminal count.
                    if (bus.PREADY) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        rsp_valid_q <= onehot(gnt);
                        rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
                        state       <= S_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        // This wait cycle brings the count to TIMEOUT_CYC: abort.
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        rsp_valid_q <= onehot(gnt);
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWrite    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Directed self-checking bench for gpio_apb_arbiter (N_REQ=4, AW=8, DW=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Ends with one summary line.
module tb_gpio_apb_arbiter;
    logic PCLK;
    logic PRESETn;

    gpio_apb_arbiter_if #(.N_REQ(4), .AW(8), .DW(16)) bus ();

    gpio_apb_arbiter #(.N_REQ(4), .AW(8), .DW(16), .TIMEOUT_CYC(16)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge PCLK);
    endtask

    task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [15:0] d);
        bus.req_write[i]       = w;
        bus.req_addr[i*8 +: 8]  = a;
        bus.req_wdata[i*16 +: 16] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int          ord [5];
        logic [3:0]  one;
        logic [7:0]  ea;

        ord = '{0, 1, 2, 3, 0};
        PRESETn        = 1'b0;
        bus.req_valid  = '0;
        bus.req_write  = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.PRDATA     = '0;
        bus.PREADY     = 1'b1;

        // Reset state
        repeat (2) nxt();
        check("rst_psel",    bus.PSEL, 0);
        check("rst_penable", bus.PENABLE, 0);
        check("rst_pwrite",  bus.PWrite, 0);
        check("rst_handsh",  {bus.req_ready, bus.rsp_valid, 7'd0, bus.rsp_err}, 0);
        check("rst_addr",    {bus.PADDR, bus.PWDATA}, 0);
        check("rst_rdata",   bus.rsp_rdata, 0);
        PRESETn = 1'b1;
        nxt();

        // Single write from requester 0
        set_req(0, 1'b1, 8'h04, 16'h00FF);
        bus.req_valid = 4'b0001;
        nxt();
        check("wr_setup_sel", {bus.PSEL, bus.PENABLE, bus.PWrite}, 3'b101);
        check("wr_setup_rdy", bus.req_ready, 4'b0001);
        check("wr_setup_adr", bus.PADDR, 8'h04);
        check("wr_setup_dat", bus.PWDATA, 16'h00FF);
        bus.req_valid = 4'b0000;
        nxt();
        check("wr_acc_sel",  {bus.PSEL, bus.PENABLE, bus.PWrite}, 3'b111);
        check("wr_acc_hs",   {bus.req_ready, bus.rsp_valid}, 0);
        check("wr_acc_adr",  {bus.PADDR, bus.PWDATA}, {8'h04, 16'h00FF});
        nxt();
        check("wr_rsp_vld",  bus.rsp_valid, 4'b0001);
        check("wr_rsp_err",  bus.rsp_err, 0);
        check("wr_rsp_idle", {bus.PSEL, bus.PENABLE, bus.PWrite}, 0);

        // Single read from requester 2
        set_req(2, 1'b0, 8'h00, 16'h0000);
        bus.req_valid = 4'b0100;
        bus.PRDATA    = 16'hA5C3;
        nxt();
        check("rd_setup_rdy", bus.req_ready, 4'b0100);
        check("rd_setup_sel", {bus.PSEL, bus.PENABLE, bus.PWrite}, 3'b100);
        bus.req_valid = 4'b0000;
        nxt();
        check("rd_acc_sel",  {bus.PSEL, bus.PENABLE, bus.PWrite}, 3'b110);
        check("rd_acc_adr",  bus.PADDR, 8'h00);
        nxt();
        check("rd_rsp_vld",  bus.rsp_valid, 4'b0100);
        check("rd_rsp_data", bus.rsp_rdata, 16'hA5C3);
        check("rd_rsp_err",  bus.rsp_err, 0);
        bus.PRDATA = 16'h0000;

        // Three wait states on a write from requester 1
        set_req(1, 1'b1, 8'h22, 16'h1234);
        bus.req_valid = 4'b0010;
        bus.PREADY    = 1'b0;
        nxt();
        check("ws_setup_rdy", bus.req_ready, 4'b0010);
        bus.req_valid = 4'b0000;
        for (int a = 1; a <= 4; a++) begin
            nxt();
            check($sformatf("ws_acc%0d_sel", a), {bus.PSEL, bus.PENABLE}, 2'b11);
            check($sformatf("ws_acc%0d_bus", a), {bus.PADDR, bus.PWDATA}, {8'h22, 16'h1234});
            check($sformatf("ws_acc%0d_rsp", a), bus.rsp_valid, 0);
            if (a == 4) bus.PREADY = 1'b1;
        end
        nxt();
        check("ws_rsp_vld",  bus.rsp_valid, 4'b0010);
        check("ws_rsp_data", bus.rsp_rdata, 0);

        // Reset asserted in the middle of ACCESS
        set_req(3, 1'b0, 8'h33, 16'h0000);
        bus.req_valid = 4'b1000;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = 16'hBEEF;
        nxt();
        check("mr_setup_rdy", bus.req_ready, 4'b1000);
        bus.req_valid = 4'b0000;
        nxt();
        check("mr_acc_sel", {bus.PSEL, bus.PENABLE}, 2'b11);
        #1 PRESETn = 1'b0;
        #1;
        check("mr_now_sel", {bus.PSEL, bus.PENABLE, bus.PWrite}, 0);
        check("mr_now_adr", {bus.PADDR, bus.PWDATA}, 0);
        check("mr_now_hs",  {bus.req_ready, bus.rsp_valid, bus.rsp_err}, 0);
        nxt();
        PRESETn    = 1'b1;
        bus.PREADY = 1'b1;
        bus.PRDATA = 16'h0000;
        nxt();
        check("mr_no_rsp", {bus.rsp_valid, bus.PSEL}, 0);

        // Contention: all four write together and re-request after each response
        for (int i = 0; i < 4; i++) begin
            ea = 8'h10 * 8'(i + 1);
            set_req(i, 1'b1, ea, 16'h1000 + 16'(i));
        end
        bus.req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            one = 4'b0001 << ord[t];
            ea  = 8'h10 * 8'(ord[t] + 1);
            nxt();
            check($sformatf("ct%0d_grant", t), bus.req_ready, one);
            check($sformatf("ct%0d_paddr", t), bus.PADDR, ea);
            bus.req_valid[ord[t]] = 1'b0;
            nxt();
            check($sformatf("ct%0d_pwdata", t), bus.PWDATA, 16'h1000 + 16'(ord[t]));
            nxt();
            check($sformatf("ct%0d_rsp", t), bus.rsp_valid, one);
            if (t < 4) bus.req_valid[ord[t]] = 1'b1;
            else       bus.req_valid = 4'b0000;
        end
        nxt();
        check("ct_idle", {bus.PSEL, bus.req_ready}, 0);

`ifdef APB_TIMEOUT_EN
        // Stuck slave on requester 1, requester 2 queued behind it
        set_req(1, 1'b0, 8'h51, 16'h0000);
        set_req(2, 1'b1, 8'h52, 16'h5252);
        bus.req_valid = 4'b0110;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = 16'hFFFF;
        nxt();
        check("to_setup_rdy", bus.req_ready, 4'b0010);
        bus.req_valid[1] = 1'b0;
        for (int a = 1; a <= 16; a++) begin
            nxt();
            if (a == 1 || a == 16) begin
                check($sformatf("to_acc%0d_sel", a), {bus.PSEL, bus.PENABLE}, 2'b11);
                check($sformatf("to_acc%0d_rsp", a), bus.rsp_valid, 0);
            end
        end
        nxt();
        check("to_abort_vld", bus.rsp_valid, 4'b0010);
        check("to_abort_err", bus.rsp_err, 1);
        check("to_abort_dat", bus.rsp_rdata, 0);
        check("to_abort_sel", {bus.PSEL, bus.PENABLE}, 0);
        bus.PREADY = 1'b1;
        nxt();
        check("to_next_rdy", bus.req_ready, 4'b0100);
        check("to_next_adr", bus.PADDR, 8'h52);
        bus.req_valid = 4'b0000;
        nxt();
        nxt();
        check("to_next_vld", bus.rsp_valid, 4'b0100);
        check("to_next_err", bus.rsp_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_apb_arbiter.md
Name: gpio_apb_arbiter

Overview:
- Round-robin APB master that shares the GPIO APB slave port among N_REQ internal requesters, such as CPU bridge, pattern sequencer and debug port.
- Each requester posts a single read or write command. The block serializes the commands into compliant APB SETUP/ACCESS transfers and returns a per-requester response.
- Sits between the requesters and the GPIO slave's PSEL/PENABLE/PWrite/PADDR/PWDATA/PRDATA/PREADY pins.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- AW, 8, APB address width.
- DW, 16, APB data width.
- TIMEOUT_CYC, 16, ACCESS-phase cycles before abort. Used only with APB_TIMEOUT_EN.

Ports:
- PCLK  input  1  clock; all logic on posedge.
- PRESETn  input  1  reset.
- req_valid  input  N_REQ  requester i has a command pending.
- req_write  input  N_REQ  1 = write, 0 = read, per requester.
- req_addr  input  N_REQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  input  N_REQ*DW  packed write data; requester i at [i*DW +: DW].
- req_ready  output  N_REQ  one-cycle pulse: command of requester i accepted.
- rsp_valid  output  N_REQ  one-cycle pulse: transfer of requester i completed.
- rsp_rdata  output  DW  read data, valid with any rsp_valid bit.
- rsp_err  output  1  transfer aborted, valid with rsp_valid.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWrite  output  1  APB direction.
- PADDR  output  AW  APB address.
- PWDATA  output  DW  APB write data.
- PRDATA  input  DW  APB read data.
- PREADY  input  1  APB ready.

Interface decision: one clock; reset is asynchronous and active-low (PCLK, PRESETn).

Behaviour:
- Reset (PRESETn low, asynchronous):
  - State = IDLE.
  - PSEL, PENABLE, PWrite, req_ready, rsp_valid and rsp_err = 0.
  - PADDR, PWDATA and rsp_rdata = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - Applies immediately, including mid-transfer: PSEL drops the same instant and no rsp_valid is issued for the killed transfer.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid bit is set at a posedge, grant the first set bit searching from the pointer upward, mod N_REQ.
  - Latch req_write, req_addr and req_wdata of the granted requester into PWrite, PADDR and PWDATA.
  - Set grant = g, pointer = (g+1) mod N_REQ, and go to SETUP.
  - No request: stay in IDLE with PSEL = 0, PENABLE = 0, PWrite = 0; PADDR and PWDATA hold their last values.
- SETUP (exactly one cycle):
  - PSEL = 1, PENABLE = 0.
  - req_ready[g] = 1 during this cycle only.
  - Next state ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1; PADDR, PWDATA and PWrite stable.
  - Stay while PREADY = 0.
  - On a posedge with PREADY = 1:
    - Capture rsp_rdata = PRDATA for a read, or 0 for a write.
    - rsp_valid[g] = 1 for the next cycle, with rsp_err = 0.
    - PSEL and PENABLE drop, and the state returns to IDLE.
- Throughput: at least one IDLE cycle between transfers. With PREADY tied high the block completes one transfer per 3 cycles:
  - request sampled at edge 0;
  - SETUP in cycle 1;
  - ACCESS in cycle 2;
  - rsp_valid and IDLE in cycle 3, where the next grant is sampled;
  - next SETUP in cycle 4.
- Requester rules:
  - Hold req_valid and the command fields stable until req_ready is seen.
  - Deassert req_valid in the req_ready cycle unless another command follows.
  - A req_valid bit dropped before it is granted is never issued.
  - A requester may post its next command while its previous response is outstanding. The command is only sampled in IDLE, so ordering per requester is preserved.
- Pointer behaviour: it advances only on a grant. Simultaneous requests are served in rotating order; no requester waits more than N_REQ-1 transfers.
- rsp_valid is one-hot or zero. req_ready is one-hot or zero. Both are never set in the same cycle.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entering ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When it reaches TIMEOUT_CYC, the transfer ends: PSEL and PENABLE drop and the state returns to IDLE.
  - rsp_valid[g] = 1 with rsp_err = 1 and rsp_rdata = 0.
  - PREADY arriving in the same cycle as the terminal count wins, giving a normal completion with rsp_err = 0.
- Not defined: ACCESS waits indefinitely for PREADY, rsp_err is constant 0, and there is no counter logic.

Test Plan:
- Write: req0 write addr 0x04, data 0x00FF, PREADY = 1.
  - Expect SETUP then ACCESS with PADDR = 0x04, PWDATA = 0x00FF, PWrite = 1.
  - req_ready[0] in SETUP; rsp_valid[0] 3 cycles after the request edge; rsp_err = 0.
- Read: req2 read addr 0x00, slave returns PRDATA = 0xA5C3.
  - Expect rsp_valid[2] with rsp_rdata = 0xA5C3 and PWrite = 0 throughout.
- Contention: all four requesters assert writes at the same edge and re-request after each response.
  - Expect grant order 0, 1, 2, 3, 0, and each PADDR to match its requester.
- Wait states: PREADY held low for 3 ACCESS cycles.
  - Expect PSEL = PENABLE = 1 and stable PADDR/PWDATA for 4 ACCESS cycles, then rsp_valid.
- Reset: PRESETn pulsed low mid-ACCESS.
  - Expect PSEL, PENABLE and all outputs at 0 immediately, no rsp_valid, pointer = 0.
  - The first post-reset grant goes to requester 0.
- APB_TIMEOUT_EN with TIMEOUT_CYC = 16 and PREADY stuck low.
  - Expect the abort after 16 ACCESS cycles, rsp_err = 1, rsp_rdata = 0, and the next queued request served normally.
